decodificador_eventos: RTL and testbench

Receiving end of the debounced-button toggle signals. Each button channel flips a level (`Senal_Reset`, `Senal_Test`, `Senal_Medicina`, `Senal_Energia`) once per debounced press, in a clock domain derived from the button filters. This block brings those levels into the system clock domain and turns every flip into exactly one event. It queues the events in a small FIFO and delivers them to the pet state machine over a valid/ready handshake.

---
 rtl/eventos_pkg.sv | 33 +++
 rtl/decodificador_eventos_detector_cambio.sv | 63 ++++++
 rtl/decodificador_eventos.sv | 131 +++++++++++++
 tb/tb_decodificador_eventos.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eventos_pkg.sv
// Shared definitions for the event decoder: event codes, channel count and
// the fixed arbitration order used when several channels are pending.
package eventos_pkg;

    localparam int NUM_CANALES = 4;
    localparam int CODE_W      = 2;

    // Channel index and event code coincide: channel i produces code i.
    typedef enum logic [1:0] {
        EV_RESET    = 2'd0,
        EV_TEST     = 2'd1,
        EV_MEDICINA = 2'd2,
        EV_ENERGIA  = 2'd3
    } codigo_e;

    // Arbitration order, highest priority first.
    localparam codigo_e PRIORIDAD [NUM_CANALES] = '{EV_RESET, EV_TEST, EV_MEDICINA, EV_ENERGIA};

    // Returns the code of the highest-priority pending channel (EV_RESET if none).
    function automatic logic [CODE_W-1:0] seleccionar(input logic [NUM_CANALES-1:0] pend);
        logic [CODE_W-1:0] sel;
        sel = 2'd0;
        for (int i = NUM_CANALES - 1; i >= 0; i--) begin
            if (pend[PRIORIDAD[i]]) begin
                sel = PRIORIDAD[i];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/decodificador_eventos_detector_cambio.sv
// Per-channel change detector: synchronizes an asynchronous toggle level,
// primes the previous-value register after reset, and emits a one-cycle
// pulse for every change of the synchronized level.
module detector_cambio #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic senal_i,
    output logic pulso_o
);

    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIME_FIN = PW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PW-1:0]          prime_q;
    logic                   cebando_s;
    logic                   sinc_s;

    // Derived view of the chain output and priming window.
    always_comb begin
        sinc_s    = sync_q[SYNC_STAGES-1];
        cebando_s = (prime_q != PRIME_FIN);
    end

    // Synchronizer chain; stage 0 is the metastability-facing flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], senal_i};
        end
    end

    // Priming counter: masks pulses until the chain holds the real input level,
    // so the unknown power-up level of the source flop never becomes an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q <= {PW{1'b0}};
        end else if (cebando_s) begin
            prime_q <= prime_q + PW'(1);
        end else begin
            prime_q <= prime_q;
        end
    end

    // Previous-value register tracks the synchronized level every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sinc_s;
        end
    end

    // Any difference after priming is one event; edge direction is irrelevant.
    always_comb begin
        pulso_o = (sinc_s ^ prev_q) & ~cebando_s;
    end

endmodule

// File: rtl/decodificador_eventos.sv
// Event decoder top: four change detectors feed per-channel pending bits,
// a fixed-priority arbiter moves one pending bit per cycle into a small
// register FIFO, and the FIFO head is offered over valid/ready.
import eventos_pkg::*;

module decodificador_eventos #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               Senal_Reset,
    input  logic                               Senal_Test,
    input  logic                               Senal_Medicina,
    input  logic                               Senal_Energia,
    input  logic                               evento_ready,
    output logic                               evento_valid,
    output logic [1:0]                         evento_codigo,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    eventos_pend,
    output logic                               desborde
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [NUM_CANALES-1:0] senal_s;
    logic [NUM_CANALES-1:0] pulso_s;

    logic [NUM_CANALES-1:0] pend_q, pend_d;
    logic                   desb_q, desb_d;
    logic [CODE_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic                   pop_s, push_s, lleno_s, push_ok_s;
    logic [CODE_W-1:0]      grant_s;

    // Channel index equals event code.
    always_comb begin
        senal_s = {Senal_Energia, Senal_Medicina, Senal_Test, Senal_Reset};
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CANALES; g++) begin : g_det
            detector_cambio #(.SYNC_STAGES(SYNC_STAGES)) u_det (
                .clk     (clk),
                .reset   (reset),
                .senal_i (senal_s[g]),
                .pulso_o (pulso_s[g])
            );
        end
    endgenerate

    // Handshake, arbitration and next-state for pending bits and FIFO pointers.
    always_comb begin
        pop_s     = (cnt_q != {CNT_W{1'b0}}) && evento_ready;
        lleno_s   = (cnt_q == CNT_W'(FIFO_DEPTH));
        push_ok_s = ~lleno_s | pop_s;
        grant_s   = seleccionar(pend_q);
        push_s    = (|pend_q) && push_ok_s;

        pend_d = pend_q;
        desb_d = desb_q;
        if (push_s) begin
            pend_d[grant_s] = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        // A pulse on an already-pending channel is lost; a granted bit
        // still counts as pending during its grant cycle.
        for (int i = 0; i < NUM_CANALES; i++) begin
            if (pulso_s[i]) begin
                if (pend_q[i]) begin
                    desb_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                end
            end else begin
                pend_d[i] = pend_d[i];
            end
        end

        wr_d = push_s ? (wr_q + PTR_W'(1)) : wr_q;
        rd_d = pop_s  ? (rd_q + PTR_W'(1)) : rd_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pending bits, sticky overflow flag and FIFO pointers/occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= {NUM_CANALES{1'b0}};
            desb_q <= 1'b0;
            wr_q   <= {PTR_W{1'b0}};
            rd_q   <= {PTR_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            pend_q <= pend_d;
            desb_q <= desb_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    // FIFO storage; cleared on reset so the idle head code reads as 00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
        end else if (push_s) begin
            mem_q[wr_q] <= grant_s;
        end else begin
            mem_q[wr_q] <= mem_q[wr_q];
        end
    end

    // Outputs are taken straight from registers.
    always_comb begin
        evento_valid  = (cnt_q != {CNT_W{1'b0}});
        evento_codigo = mem_q[rd_q];
        eventos_pend  = cnt_q;
        desborde      = desb_q;
    end

endmodule

// File: tb/tb_decodificador_eventos.sv
// Self-checking bench for decodificador_eventos: directed sequences, a
// table of simultaneous-toggle patterns and a randomized run against a
// queue-based reference model.
module tb_decodificador_eventos;

    localparam int N = 2;
    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] sen;
    logic       ready;
    logic       valid;
    logic [1:0] codigo;
    logic [2:0] pend;
    logic       desb;

    int n_chk;
    int n_fail;

    decodificador_eventos #(.SYNC_STAGES(N), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .Senal_Reset    (sen[0]),
        .Senal_Test     (sen[1]),
        .Senal_Medicina (sen[2]),
        .Senal_Energia  (sen[3]),
        .evento_ready   (ready),
        .evento_valid   (valid),
        .evento_codigo  (codigo),
        .eventos_pend   (pend),
        .desborde       (desb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    logic  m_hist [4][$];
    logic  m_pend [4];
    logic  m_ovf;
    int    m_q [$];

    task automatic model_init();
        for (int c = 0; c < 4; c++) begin
            m_hist[c].delete();
            for (int j = 0; j < N + 2; j++) m_hist[c].push_back(sen[c]);
            m_pend[c] = 1'b0;
        end
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    // Advances the model by one rising edge using the current inputs.
    task automatic model_step();
        logic pulse [4];
        logic npend [4];
        bit   do_pop, push_ok, found;
        int   g;
        for (int c = 0; c < 4; c++) begin
            m_hist[c].push_back(sen[c]);
            void'(m_hist[c].pop_front());
            pulse[c] = (m_hist[c][0] != m_hist[c][1]);
            npend[c] = m_pend[c];
        end
        do_pop  = (m_q.size() > 0) && ready;
        push_ok = (m_q.size() < D) || do_pop;
        found = 0; g = 0;
        for (int c = 0; c < 4; c++) if (!found && m_pend[c]) begin found = 1; g = c; end
        if (found && push_ok) npend[g] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (pulse[c]) begin
                if (m_pend[c]) m_ovf = 1'b1;
                else npend[c] = 1'b1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
        if (found && push_ok) m_q.push_back(g);
        for (int c = 0; c < 4; c++) m_pend[c] = npend[c];
    endtask

    task automatic model_compare();
        chk("rnd_valid", valid, (m_q.size() > 0));
        chk("rnd_pend", pend, m_q.size());
        chk("rnd_desb", desb, m_ovf);
        if (m_q.size() > 0) chk("rnd_codigo", codigo, m_q[0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(8);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0] mask;
        int         cnt;
        logic [7:0] codes;   // expected pop order, first code in [1:0]
    } vec_t;

    vec_t tbl [5];

    initial begin
        int n_ev;
        logic [7:0] cs;
        n_chk = 0; n_fail = 0;

        tbl[0] = '{mask: 4'b0100, cnt: 1, codes: 8'b00_00_00_10};
        tbl[1] = '{mask: 4'b1111, cnt: 4, codes: 8'b11_10_01_00};
        tbl[2] = '{mask: 4'b1010, cnt: 2, codes: 8'b00_00_11_01};
        tbl[3] = '{mask: 4'b0101, cnt: 2, codes: 8'b00_00_10_00};
        tbl[4] = '{mask: 4'b1001, cnt: 2, codes: 8'b00_00_11_00};

        // Reset with inputs at 1, then release: priming must hide the level.
        sen = 4'hF; ready = 1'b0; reset = 1'b1;
        step(3);
        chk("rst_valid", valid, 1'b0);
        chk("rst_codigo", codigo, 2'b00);
        chk("rst_pend", pend, 3'd0);
        chk("rst_desb", desb, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("prime_pend", pend, 3'd0);
            chk("prime_valid", valid, 1'b0);
            chk("prime_desb", desb, 1'b0);
        end

        // Single medicina toggle: valid exactly 4 edges later, for one cycle.
        ready = 1'b1;
        sen[2] = ~sen[2];
        step(3);
        chk("lat_early", valid, 1'b0);
        step(1);
        chk("lat_valid", valid, 1'b1);
        chk("lat_codigo", codigo, 2'b10);
        step(1);
        chk("lat_after", valid, 1'b0);
        chk("lat_pend", pend, 3'd0);

        // Table: simultaneous toggles with ready low, then drain in priority order.
        for (int t = 0; t < 5; t++) begin
            ready = 1'b0;
            sen = sen ^ tbl[t].mask;
            step(8);
            chk("tbl_pend", pend, tbl[t].cnt);
            ready = 1'b1;
            cs = tbl[t].codes;
            for (int j = 0; j < tbl[t].cnt; j++) begin
                chk("tbl_valid", valid, 1'b1);
                chk("tbl_codigo", codigo, cs[1:0]);
                cs = cs >> 2;
                step(1);
            end
            chk("tbl_empty", valid, 1'b0);
        end

        // Test channel toggled every 3 cycles with ready high: no loss.
        ready = 1'b1; n_ev = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 24 && c % 3 == 0) sen[1] = ~sen[1];
            step(1);
            if (valid) begin
                n_ev++;
                chk("str_codigo", codigo, 2'b01);
            end
        end
        chk("str_count", n_ev, 8);
        chk("str_desb", desb, 1'b0);

        // Full FIFO plus two energia toggles while stalled: one is lost.
        ready = 1'b0;
        sen = sen ^ 4'b1111;
        step(8);
        chk("ovf_full", pend, 3'd4);
        sen[3] = ~sen[3];
        step(10);
        chk("ovf_hold", desb, 1'b0);
        sen[3] = ~sen[3];
        step(10);
        chk("ovf_desb", desb, 1'b1);
        ready = 1'b1; n_ev = 0;
        for (int c = 0; c < 15; c++) begin
            if (valid) n_ev++;
            step(1);
        end
        chk("ovf_count", n_ev, 5);
        chk("ovf_sticky", desb, 1'b1);

        // Reset while three events are queued.
        do_reset();
        chk("rr_desb_clr", desb, 1'b0);
        ready = 1'b0;
        sen = sen ^ 4'b0111;
        step(8);
        chk("rr_pend3", pend, 3'd3);
        chk("rr_valid", valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("rr_async_valid", valid, 1'b0);
        chk("rr_async_pend", pend, 3'd0);
        step(2);
        reset = 1'b0;
        ready = 1'b1; n_ev = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (valid) n_ev++;
        end
        chk("rr_no_stale", n_ev, 0);

        // Randomized run against the reference model.
        do_reset();
        step(5);
        model_init();
        for (int c = 0; c < 400; c++) begin
            model_compare();
            for (int ch = 0; ch < 4; ch++)
                if ($urandom_range(0, 3) == 0) sen[ch] = ~sen[ch];
            ready = ($urandom_range(0, 1) == 1);
            model_step();
            step(1);
        end
        for (int c = 0; c < 20; c++) begin
            model_compare();
            ready = 1'b1;
            model_step();
            step(1);
        end
        chk("rnd_drained", pend, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
